// File: rtl/pcs_pkg.sv
// rtl/pcs_pkg.sv - shared PCS constants for the 64b/66b transmit path
package pcs_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int HDR_WIDTH  = 2;

  // Last value of the gearbox sequence counter; this slot is the pause slot.
  localparam int GB_SEQ_MAX = 32;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

endpackage

// File: rtl/tx_gearbox.sv
// rtl/tx_gearbox.sv - 64b/66b transmit gearbox, 32 payload words + 16 headers in, 33 PMA words out
module tx_gearbox #(
  parameter int DATA_WIDTH = pcs_pkg::DATA_WIDTH,
  parameter int HDR_WIDTH  = pcs_pkg::HDR_WIDTH,
  parameter int TRDY_LEAD  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [HDR_WIDTH-1:0]  i_rx_hdr,
  input  logic                  i_rx_data_valid,
  output logic                  o_tx_trdy,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_data_valid,
  output logic                  o_err_overflow,
  output logic                  o_err_underflow
);

  import pcs_pkg::*;

  localparam int ACC_WIDTH = 2 * DATA_WIDTH;
  localparam int EXT_WIDTH = DATA_WIDTH + HDR_WIDTH;
  localparam logic [5:0] SEQ_PAUSE = 6'(GB_SEQ_MAX);
  localparam logic [5:0] SEQ_TRDY  = 6'(GB_SEQ_MAX - TRDY_LEAD);

  logic [5:0]            seq, seq_next;
  logic                  ph, ph_next;
  logic                  started;
  logic [DATA_WIDTH-1:0] rem, rem_next;
  logic [5:0]            fill, fill_next;
  logic                  pause, step, consume;
  logic [DATA_WIDTH-1:0] word;
  logic [HDR_WIDTH-1:0]  hdr;
  logic [EXT_WIDTH-1:0]  ext;
  logic [ACC_WIDTH-1:0]  acc;
  logic [DATA_WIDTH-1:0] out_word;

  assign o_tx_trdy = !(started && seq == SEQ_TRDY);

  always_comb begin
    pause   = started && (seq == SEQ_PAUSE);
    step    = started || i_rx_data_valid;
    consume = step && !pause;

    // A missing word is replaced by zeros so later headers keep their bit offsets.
    word = i_rx_data_valid ? i_rx_data : '0;
    hdr  = i_rx_data_valid ? i_rx_hdr : '0;
    ext  = ph ? {{HDR_WIDTH{1'b0}}, word} : {word, hdr};
    acc  = {{DATA_WIDTH{1'b0}}, rem} | ({{(ACC_WIDTH - EXT_WIDTH){1'b0}}, ext} << fill);

    seq_next  = seq;
    ph_next   = ph;
    rem_next  = rem;
    fill_next = fill;
    out_word  = acc[DATA_WIDTH-1:0];

    if (pause) begin
      // Exactly one full word is left over after 16 blocks; flush it.
      seq_next  = '0;
      rem_next  = '0;
      fill_next = '0;
      out_word  = rem;
    end else if (consume) begin
      seq_next  = seq + 6'd1;
      ph_next   = !ph;
      rem_next  = acc[ACC_WIDTH-1:DATA_WIDTH];
      fill_next = ph ? fill : fill + 6'(HDR_WIDTH);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      seq             <= '0;
      ph              <= 1'b0;
      started         <= 1'b0;
      rem             <= '0;
      fill            <= '0;
      o_tx_data       <= '0;
      o_tx_data_valid <= 1'b0;
      o_err_overflow  <= 1'b0;
      o_err_underflow <= 1'b0;
    end else begin
      seq             <= seq_next;
      ph              <= ph_next;
      started         <= started || i_rx_data_valid;
      rem             <= rem_next;
      fill            <= fill_next;
      if (step) begin
        o_tx_data       <= out_word;
        o_tx_data_valid <= 1'b1;
      end
      o_err_overflow  <= pause && i_rx_data_valid;
      o_err_underflow <= consume && !i_rx_data_valid;
    end
  end

endmodule

// File: tb/tb_tx_gearbox.sv
// tb/tb_tx_gearbox.sv - scoreboard bench for tx_gearbox against a serial bit-stream reference
module tb_tx_gearbox;
  import pcs_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [31:0] i_rx_data = '0;
  logic [1:0]  i_rx_hdr = '0;
  logic        i_rx_data_valid = 1'b0;
  logic        o_tx_trdy;
  logic [31:0] o_tx_data;
  logic        o_tx_data_valid;
  logic        o_err_overflow;
  logic        o_err_underflow;

  always #5 i_clk = ~i_clk;

  tx_gearbox dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_rx_data      (i_rx_data),
    .i_rx_hdr       (i_rx_hdr),
    .i_rx_data_valid(i_rx_data_valid),
    .o_tx_trdy      (o_tx_trdy),
    .o_tx_data      (o_tx_data),
    .o_tx_data_valid(o_tx_data_valid),
    .o_err_overflow (o_err_overflow),
    .o_err_underflow(o_err_underflow)
  );

  int total = 0;
  int bad = 0;

  bit          stream_q[$];
  logic [31:0] exp_q[$];
  int          uf_q[$];
  int          ov_q[$];
  int          out_idx = 0;
  bit          tail_ok = 1'b0;
  bit          seen_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Serial reference: hdr[0] first, then data[0..31]; every 32 bits make one output word.
  function automatic void push_bits(input logic [31:0] d, input logic [1:0] h, input bit with_hdr);
    if (with_hdr) begin
      stream_q.push_back(h[0]);
      stream_q.push_back(h[1]);
    end
    for (int i = 0; i < 32; i++) stream_q.push_back(d[i]);
    while (stream_q.size() >= 32) begin
      logic [31:0] w;
      for (int i = 0; i < 32; i++) w[i] = stream_q.pop_front();
      exp_q.push_back(w);
    end
  endfunction

  always @(negedge i_clk) begin
    if (seen_valid && !o_tx_data_valid) check_eq("valid_gap", o_tx_data_valid, 1);
    if (o_tx_data_valid) begin
      seen_valid = 1'b1;
      if (exp_q.size() > 0) check_eq("data", o_tx_data, exp_q.pop_front());
      else if (!tail_ok) check_eq("unexpected_word", o_tx_data_valid, 0);
    end
    if (o_err_underflow) begin
      if (uf_q.size() > 0) check_eq("uf_idx", out_idx, uf_q.pop_front());
      else if (!tail_ok) check_eq("uf_spurious", o_err_underflow, 0);
    end
    if (o_err_overflow) begin
      if (ov_q.size() > 0) check_eq("ov_idx", out_idx, ov_q.pop_front());
      else check_eq("ov_spurious", o_err_overflow, 0);
    end
    if (o_tx_data_valid) out_idx++;
  end

  task automatic drive(input bit v, input logic [31:0] d, input logic [1:0] h);
    i_rx_data_valid = v;
    i_rx_data = d;
    i_rx_hdr = h;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    i_reset_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      i_rx_data = $urandom;
      i_rx_hdr = 2'($urandom);
      i_rx_data_valid = 1'($urandom);
      @(posedge i_clk);
      #1;
      if (i == 0) begin
        check_eq("pre_rst_pending", exp_q.size(), 0);
        stream_q.delete();
        exp_q.delete();
        uf_q.delete();
        ov_q.delete();
        out_idx = 0;
        seen_valid = 1'b0;
        tail_ok = 1'b0;
      end
      check_eq("rst_data", o_tx_data, 0);
      check_eq("rst_valid", o_tx_data_valid, 0);
      check_eq("rst_trdy", o_tx_trdy, 1);
      check_eq("rst_ovf", o_err_overflow, 0);
      check_eq("rst_udf", o_err_underflow, 0);
    end
    i_reset_n = 1'b1;
    i_rx_data_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    i_rx_data_valid = 1'b0;
    tail_ok = 1'b1;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check_eq({tag, "_drain"}, exp_q.size(), 0);
    check_eq({tag, "_uf_left"}, uf_q.size(), 0);
    check_eq({tag, "_ov_left"}, ov_q.size(), 0);
  endtask

  function automatic logic [1:0] pick_hdr(input bit is_hdr);
    if (!is_hdr) return 2'($urandom);
    return ($urandom_range(0, 1) != 0) ? SYNC_DATA : SYNC_CTRL;
  endfunction

  // Slot-by-slot stimulus ignoring ready; slot s has seq = s % 33.
  task automatic run_manual(input int n_slots, input int ov_slot, input int uf_slot);
    int c = 0;
    logic [31:0] d;
    logic [1:0] h;
    for (int s = 0; s < n_slots; s++) begin
      d = $urandom;
      h = pick_hdr(c % 2 == 0);
      if (s % 33 == 32) begin
        if (s == ov_slot) begin
          ov_q.push_back(s);
          drive(1'b1, 32'hDEAD_BEEF, h);
        end else begin
          drive(1'b0, d, h);
        end
      end else begin
        if (s == uf_slot) begin
          uf_q.push_back(s);
          push_bits(32'h0, 2'b00, c % 2 == 0);
          drive(1'b0, d, h);
        end else begin
          push_bits(d, h, c % 2 == 0);
          drive(1'b1, d, h);
        end
        c++;
      end
    end
  endtask

  // Scrambler model: ready is registered once, valid once more, so valid(c) = trdy(c-2).
  task automatic run_paced();
    bit d1 = 1'b1;
    bit d2 = 1'b1;
    bit t, v;
    int w = 0;
    int cyc = 0;
    int slot = -1;
    int last_low = -1;
    int lows = 0;
    logic [31:0] d;
    logic [1:0] h;
    while (w < 64 && cyc < 400) begin
      t = o_tx_trdy;
      v = d2;
      d2 = d1;
      d1 = t;
      if (slot >= 0 || v) slot++;
      if (!t) begin
        lows++;
        check_eq("trdy_seq", slot % 33, 30);
        if (last_low >= 0) check_eq("trdy_period", slot - last_low, 33);
        last_low = slot;
      end
      if (slot >= 0 && slot % 33 == 32) check_eq("pause_empty", v, 0);
      d = $urandom;
      h = pick_hdr(w % 2 == 0);
      if (v) begin
        push_bits(d, h, w % 2 == 0);
        w++;
      end
      drive(v, d, h);
      cyc++;
    end
    check_eq("paced_words", w, 64);
    check_eq("trdy_lows", lows, 2);
  endtask

  initial begin
    do_reset(4);
    drive(1'b0, 32'h0, 2'b00);
    drive(1'b0, 32'h0, 2'b00);
    check_eq("idle_trdy", o_tx_trdy, 1);
    check_eq("idle_valid", o_tx_data_valid, 0);

    exp_q.push_back(32'hFFFF_FFFD);
    exp_q.push_back(32'h0000_0003);
    exp_q.push_back(32'h0000_0008);
    drive(1'b1, 32'hFFFF_FFFF, SYNC_DATA);
    drive(1'b1, 32'h0000_0000, 2'b00);
    drive(1'b1, 32'h0000_0000, SYNC_CTRL);
    wait_drain("pack");

    do_reset(2);
    run_paced();
    wait_drain("pace");

    do_reset(1);
    run_manual(66, 32, -1);
    wait_drain("ovf");

    do_reset(1);
    run_manual(66, -1, 5);
    wait_drain("udf");

    do_reset(1);
    run_manual(17, -1, -1);
    do_reset(1);
    exp_q.push_back(32'hFFFF_FFFD);
    drive(1'b1, 32'hFFFF_FFFF, SYNC_DATA);
    wait_drain("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_gearbox.md
# tx_gearbox

64b/66b transmit gearbox that sits directly downstream of the scrambler and feeds the 32-bit PMA/SERDES transmit interface. It accepts 32-bit scrambled payload words plus a 2-bit sync header once per 66-bit block, and packs them into a continuous stream of 32-bit output words. It paces upstream through a ready signal that drops once every 33 cycles, so 32 input words (16 blocks, 1056 bits) become exactly 33 output words.

## Interface
- DATA_WIDTH, 32: input and output word width; only 32 is supported.
- HDR_WIDTH, 2: sync header width.
- TRDY_LEAD, 2: number of cycles by which `o_tx_trdy` low precedes the pause slot. This covers the registered ready and valid path through the scrambler.

Ports:
- i_clk  in  1  single clock
- i_reset_n  in  1  synchronous, active-low reset
- i_rx_data  in  32  scrambled payload word from the scrambler
- i_rx_hdr  in  2  sync header; sampled only on the first word of a block. It arrives already aligned with that word.
- i_rx_data_valid  in  1  input word valid
- o_tx_trdy  out  1  ready to the scrambler `i_rx_trdy`
- o_tx_data  out  32  packed word to PMA; bit 0 is transmitted first
- o_tx_data_valid  out  1  output word valid
- o_err_overflow  out  1  one-cycle pulse: valid word arrived in a pause slot
- o_err_underflow  out  1  one-cycle pulse: valid missing in a consume slot

## Operation
- State: sequence counter `seq` (0..32), block-phase bit `ph` (0 = header word, 1 = second word), bit accumulator (at most 64 bits) with fill count, and a `started` flag.
- Idle (`started`=0):
  - `seq` holds at 0 and `o_tx_trdy`=1.
  - The first cycle with `i_rx_data_valid`=1 sets `started` and is consumed as seq 0 with `ph`=0.
- Running:
  - `seq` free-runs 0→32→0.
  - `ph` toggles on every consume slot (`seq` != 32).
- Consume slot (`seq` 0..31):
  - When `ph`=0, the serial stream is extended by {data, hdr}; hdr[0] goes first.
  - When `ph`=1, it is extended by data alone.
  - The lowest 32 bits of the accumulator go out, and the remainder is kept.
  - Fill before output is 2k+34 bits on the header word of block k and 2k+34 bits on the second word. After the pause slot the fill is 0.
- Pause slot (`seq`=32): nothing is consumed, and the 32 accumulated bits are output.
- Missing valid in a consume slot:
  - `o_err_underflow` pulses.
  - 32'h0 is substituted (and hdr 2'b00 if `ph`=0).
  - `seq` and `ph` advance normally, so alignment is preserved.
- Valid in a pause slot: the word is dropped and `o_err_overflow` pulses. `ph` does not change.
- Ready: `o_tx_trdy`=0 only in the cycle where `started`=1 and `seq`==32-TRDY_LEAD (seq 30 for the default). It is 1 in all other cycles.
- Valid out: `o_tx_data_valid`=1 every cycle from the first registered output until reset.

## Timing
- Reset values:
  - o_tx_data=0, o_tx_data_valid=0
  - o_tx_trdy=1
  - both error outputs 0
  - seq=0, ph=0, fill=0, started=0
- Latency: output is registered, 1 cycle after the consume or pause slot.
- Handshake: `o_tx_trdy` is combinational from registered state. The scrambler re-registers it, and valid through the scrambler takes one more register, so the pause slot at the gearbox input is empty.
- Reset mid-operation: all state returns to its reset value on the next edge. The accumulator contents are discarded and no partial word is emitted.
- The error pulses are registered and aligned with the output word they affect.

## Structure
- Package `pcs_pkg`:
  - GB_SEQ_MAX=32
  - SYNC_DATA=2'b01, SYNC_CTRL=2'b10
  - HDR_WIDTH, DATA_WIDTH constants
- Single module; no sub-module. The counter and accumulator logic are inline.

## Test plan
- Reset: hold i_reset_n=0 for 4 cycles with random inputs → o_tx_data=0, o_tx_data_valid=0, o_tx_trdy=1, error outputs 0.
- Packing:
  - hdr=2'b01 with d0=32'hFFFF_FFFF, then d1=32'h0 → outputs 32'hFFFF_FFFD, then 32'h0000_0003.
  - Then hdr=2'b10 with d2=32'h0 → output 32'h0000_0008.
- Pacing: run with the scrambler model in place, sending a continuous stream → o_tx_trdy low exactly once per 33 cycles (at seq 30), no input at seq 32, and no error pulses.
  - 64 input words with 32 headers give 66 output words, bit-exact against a serial reference concatenation.
- Overflow: force valid at seq 32 with data 32'hDEAD_BEEF → o_err_overflow pulse, word absent from the output, following block alignment unchanged.
- Underflow: drop valid at seq 5 (`ph`=1) → o_err_underflow pulse, 32 zero bits in the stream at that position, later headers at the correct bit offsets.
- Reset mid-run: assert reset at seq 17 → outputs return to reset values. Restarting with hdr=2'b01 and d0=32'hFFFF_FFFF reproduces 32'hFFFF_FFFD as the first word.
